// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs the HPS ioctl download byte stream into 16-bit little-endian
// words and issues each word as a write request to the SDRAM controller.
//
// Ports:
//   clk_sys, reset            system clock, asynchronous active-high reset
//   ioctl_download/wr/addr/   host download interface (byte strobes, byte address,
//   dout/index                data and target index); ioctl_wait stalls the host
//   ram_req/addr/din/be/ack   single-outstanding word write port to the SDRAM controller
//   load_busy/done/words      progress: busy level, 1-cycle done pulse, acked word count
//   overflow                  sticky: a byte was dropped because the skid register was full
//   checksum                  16-bit sum of accepted bytes
//
// Optional feature: define LOADER_CHECKSUM_EN to build the checksum accumulator; when it is
// undefined checksum reads as zero and no adder is built.
module ioctl_sdram_loader #(
  parameter logic [7:0]  INDEX      = 8'd0,
  parameter logic [25:0] BASE_WADDR = 26'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        ram_req,
  output logic [25:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_be,
  input  logic        ram_ack,
  output logic        load_busy,
  output logic        load_done,
  output logic [25:0] load_words,
  output logic        overflow,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {StIdle, StCollect, StIssue, StFlush, StDone} state_e;

  state_e      state_q, state_d;
  logic        dl_q;
  logic [15:0] pw_data_q, pw_data_d;
  logic [25:0] pw_waddr_q, pw_waddr_d;
  logic [1:0]  pw_mask_q, pw_mask_d;
  logic        skid_vld_q, skid_vld_d;
  logic [26:0] skid_addr_q, skid_addr_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic [25:0] req_addr_q, req_addr_d;
  logic [15:0] req_din_q, req_din_d;
  logic [1:0]  req_be_q, req_be_d;
  logic        wait_q, wait_d;
  logic [25:0] words_q, words_d;
  logic        ovf_q, ovf_d;

  logic        dl_act, acc, start;
  logic        ack_take, drop, taken;
  logic [26:0] src_addr;
  logic [7:0]  src_data;
  logic        src_vld;
  logic [25:0] src_waddr;
  logic [1:0]  src_lane, merge_mask;
  logic [15:0] merge_data, fresh_data;
  logic        new_word;

  assign dl_act = ioctl_download & (ioctl_index == INDEX);
  assign acc    = ioctl_wr & dl_act;
  assign start  = dl_act & ~dl_q;

  // A held skid byte is older than any live strobe, so it is consumed first.
  assign src_addr   = skid_vld_q ? skid_addr_q : ioctl_addr;
  assign src_data   = skid_vld_q ? skid_data_q : ioctl_dout;
  assign src_vld    = skid_vld_q | acc;
  assign src_waddr  = src_addr[26:1];
  assign src_lane   = src_addr[0] ? 2'b10 : 2'b01;
  assign merge_data = src_addr[0] ? {src_data, pw_data_q[7:0]} : {pw_data_q[15:8], src_data};
  assign merge_mask = pw_mask_q | src_lane;
  assign fresh_data = src_addr[0] ? {src_data, 8'h00} : {8'h00, src_data};
  assign new_word   = (pw_mask_q != 2'b00) && (src_waddr != pw_waddr_q);

  always_comb begin
    state_d     = state_q;
    pw_data_d   = pw_data_q;
    pw_waddr_d  = pw_waddr_q;
    pw_mask_d   = pw_mask_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    req_addr_d  = req_addr_q;
    req_din_d   = req_din_q;
    req_be_d    = req_be_q;
    ack_take    = 1'b0;
    drop        = 1'b0;
    taken       = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d    = StCollect;
          skid_vld_d = 1'b0;
          pw_mask_d  = 2'b00;
          if (acc) begin
            taken      = 1'b1;
            pw_data_d  = fresh_data;
            pw_waddr_d = src_waddr;
            pw_mask_d  = src_lane;
          end
        end
      end
      StCollect: begin
        taken = acc;
        // Skid byte is being merged; a live byte this cycle takes its place.
        if (skid_vld_q) begin
          skid_vld_d  = acc;
          skid_addr_d = ioctl_addr;
          skid_data_d = ioctl_dout;
        end
        if (src_vld) begin
          if (new_word) begin
            req_addr_d = BASE_WADDR + pw_waddr_q;
            req_din_d  = pw_data_q;
            req_be_d   = pw_mask_q;
            pw_data_d  = fresh_data;
            pw_waddr_d = src_waddr;
            pw_mask_d  = src_lane;
            state_d    = StIssue;
          end else if (merge_mask == 2'b11) begin
            req_addr_d = BASE_WADDR + src_waddr;
            req_din_d  = merge_data;
            req_be_d   = 2'b11;
            pw_data_d  = merge_data;
            pw_waddr_d = src_waddr;
            pw_mask_d  = 2'b00;
            state_d    = StIssue;
          end else begin
            pw_data_d  = merge_data;
            pw_waddr_d = src_waddr;
            pw_mask_d  = merge_mask;
          end
        end
        if ((state_d == StCollect) && !dl_act) begin
          if (pw_mask_d != 2'b00) begin
            req_addr_d = BASE_WADDR + pw_waddr_d;
            req_din_d  = pw_data_d;
            req_be_d   = pw_mask_d;
            pw_mask_d  = 2'b00;
            state_d    = StFlush;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue, StFlush: begin
        if (acc) begin
          if (skid_vld_q) begin
            drop = 1'b1;
          end else begin
            taken       = 1'b1;
            skid_vld_d  = 1'b1;
            skid_addr_d = ioctl_addr;
            skid_data_d = ioctl_dout;
          end
        end
        if (ram_ack) begin
          ack_take = 1'b1;
          if (skid_vld_d || ((state_q == StIssue) && dl_act)) begin
            state_d = StCollect;
          end else if (pw_mask_q != 2'b00) begin
            req_addr_d = BASE_WADDR + pw_waddr_q;
            req_din_d  = pw_data_q;
            req_be_d   = pw_mask_q;
            pw_mask_d  = 2'b00;
            state_d    = StFlush;
          end else begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    words_d = start ? 26'd0 : words_q + {25'd0, ack_take};
    ovf_d   = start ? 1'b0 : (ovf_q | drop);
    // Host stays stalled until the skid byte has been merged.
    wait_d  = (state_d == StIssue) || (state_d == StFlush) || skid_vld_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      pw_data_q   <= 16'h0000;
      pw_waddr_q  <= 26'd0;
      pw_mask_q   <= 2'b00;
      skid_vld_q  <= 1'b0;
      skid_addr_q <= 27'd0;
      skid_data_q <= 8'h00;
      req_addr_q  <= 26'd0;
      req_din_q   <= 16'h0000;
      req_be_q    <= 2'b00;
      wait_q      <= 1'b0;
      words_q     <= 26'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_act;
      pw_data_q   <= pw_data_d;
      pw_waddr_q  <= pw_waddr_d;
      pw_mask_q   <= pw_mask_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      req_addr_q  <= req_addr_d;
      req_din_q   <= req_din_d;
      req_be_q    <= req_be_d;
      wait_q      <= wait_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = (start ? 16'h0000 : csum_q) + (taken ? {8'h00, ioctl_dout} : 16'h0000);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csum_q <= 16'h0000;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

  // ram_req decodes straight from the state flop so reset drops it asynchronously.
  assign ram_req    = (state_q == StIssue) || (state_q == StFlush);
  assign ram_addr   = req_addr_q;
  assign ram_din    = req_din_q;
  assign ram_be     = req_be_q;
  assign ioctl_wait = wait_q;
  assign load_busy  = (state_q == StCollect) || (state_q == StIssue) || (state_q == StFlush);
  assign load_done  = (state_q == StDone);
  assign load_words = words_q;
  assign overflow   = ovf_q;

endmodule
